cheri_trvk_ctrl: RTL and testbench



---
 rtl/cheri_pkg.sv | 37 +++
 rtl/cheri_trvk_ctrl_if.sv | 34 +++
 rtl/cheri_trvk_fifo.sv | 64 ++++++
 rtl/cheri_trvk_ctrl.sv | 127 ++++++++++++
 tb/tb_cheri_trvk_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cheri_pkg.sv
// Shared types, defaults and bitmap address helpers for the CHERI tag
// reservation/revocation controller.
package cheri_pkg;

  localparam logic [31:0] HEAP_START_DEFAULT  = 32'h8000_0000;
  localparam logic [31:0] HEAP_END_DEFAULT    = 32'h8004_0000;
  localparam logic [31:0] BITMAP_BASE_DEFAULT = 32'h8F00_0000;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] base;
    logic        need_lookup;
  } trvk_fifo_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } trvk_state_e;

  // One bitmap bit covers one 8-byte granule; 32 granules per bitmap word.
  function automatic logic [31:0] rv_word_addr(input logic [31:0] base,
                                               input logic [31:0] heap_start,
                                               input logic [31:0] bitmap_base);
    logic [31:0] g;
    g = (base - heap_start) >> 3;
    return bitmap_base + ((g >> 5) << 2);
  endfunction

  function automatic logic [4:0] rv_bit_idx(input logic [31:0] base,
                                            input logic [31:0] heap_start);
    logic [31:0] g;
    g = (base - heap_start) >> 3;
    return g[4:0];
  endfunction

endpackage

// File: rtl/cheri_trvk_ctrl_if.sv
// Returned-capability and revocation-bitmap read-port signals of the
// tag revocation controller.
interface cheri_trvk_ctrl_if;
  import cheri_pkg::*;

  logic        cap_resp_valid;
  logic        cap_resp_ready;
  logic [4:0]  cap_resp_rd;
  logic        cap_resp_tag;
  logic [31:0] cap_resp_base;

  logic        rv_req;
  logic [31:0] rv_addr;
  logic        rv_gnt;
  logic        rv_rvalid;
  logic [31:0] rv_rdata;

  // The controller side.
  modport slave (
    input  cap_resp_valid, cap_resp_rd, cap_resp_tag, cap_resp_base,
    output cap_resp_ready,
    output rv_req, rv_addr,
    input  rv_gnt, rv_rvalid, rv_rdata
  );

  // The LSU / bitmap memory side.
  modport master (
    output cap_resp_valid, cap_resp_rd, cap_resp_tag, cap_resp_base,
    input  cap_resp_ready,
    input  rv_req, rv_addr,
    output rv_gnt, rv_rvalid, rv_rdata
  );

endinterface

// File: rtl/cheri_trvk_fifo.sv
// Small synchronous FIFO of returned capabilities awaiting release;
// the head entry is presented combinationally.
module cheri_trvk_fifo
  import cheri_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  trvk_fifo_entry_t data_i,
  input  logic             pop_i,
  output trvk_fifo_entry_t data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AW:0] FULL_CNT = Depth[AW:0];

  trvk_fifo_entry_t mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/cheri_trvk_ctrl.sv
// Tag reservation/revocation controller: reserves capability-load
// destinations and releases them in order, clearing tags of revoked objects.
module cheri_trvk_ctrl
  import cheri_pkg::*;
#(
  parameter int unsigned FifoDepth  = 2,
  parameter logic [31:0] HeapStart  = HEAP_START_DEFAULT,
  parameter logic [31:0] HeapEnd    = HEAP_END_DEFAULT,
  parameter logic [31:0] BitmapBase = BITMAP_BASE_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ld_issue_i,
  input  logic [4:0]         ld_rd_i,
  cheri_trvk_ctrl_if.slave   bus,
  output logic               trsv_en_o,
  output logic [4:0]         trsv_addr_o,
  output logic               trvk_en_o,
  output logic [4:0]         trvk_addr_o,
  output logic               trvk_clrtag_o,
  output logic               busy_o
);

  trvk_state_e      state_q, state_d;
  trvk_fifo_entry_t push_entry, head;
  logic             push, pop, full, empty;
  logic             rel_en, rel_clr;
  logic             trvk_en_q, trvk_clr_q;
  logic [4:0]       trvk_addr_q;
  logic [31:0]      lookup_addr;
  logic [4:0]       lookup_bit;

  assign trsv_en_o   = ld_issue_i & (ld_rd_i != 5'd0);
  assign trsv_addr_o = ld_rd_i;

  assign bus.cap_resp_ready = ~full;
  assign push = bus.cap_resp_valid & ~full & (bus.cap_resp_rd != 5'd0);

  always_comb begin
    push_entry.rd          = bus.cap_resp_rd;
    push_entry.base        = bus.cap_resp_base;
    push_entry.need_lookup = bus.cap_resp_tag
                           & (bus.cap_resp_base >= HeapStart)
                           & (bus.cap_resp_base <  HeapEnd);
  end

  cheri_trvk_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // The head stays put for the whole lookup, so the address needs no register.
  assign lookup_addr = rv_word_addr(head.base, HeapStart, BitmapBase);
  assign lookup_bit  = rv_bit_idx(head.base, HeapStart);

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    rel_en      = 1'b0;
    rel_clr     = 1'b0;
    bus.rv_req  = 1'b0;
    bus.rv_addr = '0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          if (head.need_lookup) begin
            state_d = ST_REQ;
          end else begin
            rel_en = 1'b1;
            pop    = 1'b1;
          end
        end
      end
      ST_REQ: begin
        bus.rv_req  = 1'b1;
        bus.rv_addr = lookup_addr;
        if (bus.rv_gnt) begin
          if (bus.rv_rvalid) begin
            rel_en  = 1'b1;
            rel_clr = bus.rv_rdata[lookup_bit];
            pop     = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus.rv_rvalid) begin
          rel_en  = 1'b1;
          rel_clr = bus.rv_rdata[lookup_bit];
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      trvk_en_q   <= 1'b0;
      trvk_clr_q  <= 1'b0;
      trvk_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      trvk_en_q   <= rel_en;
      trvk_clr_q  <= rel_clr;
      trvk_addr_q <= rel_en ? head.rd : 5'd0;
    end
  end

  assign trvk_en_o     = trvk_en_q;
  assign trvk_addr_o   = trvk_addr_q;
  assign trvk_clrtag_o = trvk_clr_q;
  assign busy_o        = ~empty | (state_q != ST_IDLE);

endmodule

// File: tb/tb_cheri_trvk_ctrl.sv
// Directed bench for cheri_trvk_ctrl with hand-computed expected values.
module tb_cheri_trvk_ctrl;

  logic        clk;
  logic        rst;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic        trsv_en;
  logic [4:0]  trsv_addr;
  logic        trvk_en;
  logic [4:0]  trvk_addr;
  logic        trvk_clr;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  cheri_trvk_ctrl_if bus ();

  cheri_trvk_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .ld_issue_i    (ld_issue),
    .ld_rd_i       (ld_rd),
    .bus           (bus.slave),
    .trsv_en_o     (trsv_en),
    .trsv_addr_o   (trsv_addr),
    .trvk_en_o     (trvk_en),
    .trvk_addr_o   (trvk_addr),
    .trvk_clrtag_o (trvk_clr),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic resp(input logic v, input logic [4:0] rd, input logic tag, input logic [31:0] base);
    bus.cap_resp_valid = v;
    bus.cap_resp_rd    = rd;
    bus.cap_resp_tag   = tag;
    bus.cap_resp_base  = base;
  endtask

  task automatic trvk(input string tag, input logic en, input logic [4:0] addr, input logic clr);
    check({tag, ".en"}, 32'(trvk_en), 32'(en));
    check({tag, ".addr"}, 32'(trvk_addr), 32'(addr));
    check({tag, ".clr"}, 32'(trvk_clr), 32'(clr));
  endtask

  initial begin
    rst = 1'b1;
    ld_issue = 1'b0;
    ld_rd = 5'd0;
    resp(1'b0, 5'd0, 1'b0, 32'h0);
    bus.rv_gnt = 1'b0;
    bus.rv_rvalid = 1'b0;
    bus.rv_rdata = 32'h0;
    cyc();
    cyc();

    // reset state
    check("rst.ready", 32'(bus.cap_resp_ready), 32'd1);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.rv_req", 32'(bus.rv_req), 32'd0);
    check("rst.rv_addr", bus.rv_addr, 32'h0);
    check("rst.trsv", 32'(trsv_en), 32'd0);
    trvk("rst.trvk", 1'b0, 5'd0, 1'b0);
    rst = 1'b0;
    cyc();

    // untagged return rd=5: release one cycle after head appears, no lookup
    resp(1'b1, 5'd5, 1'b0, 32'h8000_0100);
    cyc();
    resp(1'b0, 5'd0, 1'b0, 32'h0);
    settle();
    check("untag.busy", 32'(busy), 32'd1);
    check("untag.trvk_early", 32'(trvk_en), 32'd0);
    cyc();
    trvk("untag", 1'b1, 5'd5, 1'b0);
    check("untag.rv_req", 32'(bus.rv_req), 32'd0);
    cyc();
    check("untag.pulse_end", 32'(trvk_en), 32'd0);
    check("untag.idle", 32'(busy), 32'd0);

    // tagged in-heap, base 0x8000_0008 -> granule 1: word 0x8F00_0000, bit 1
    resp(1'b1, 5'd4, 1'b1, 32'h8000_0008);
    cyc();
    resp(1'b0, 5'd0, 1'b0, 32'h0);
    settle();
    check("lk1.req_idle", 32'(bus.rv_req), 32'd0);
    cyc();
    check("lk1.req", 32'(bus.rv_req), 32'd1);
    check("lk1.addr", bus.rv_addr, 32'h8F00_0000);
    bus.rv_gnt = 1'b1;
    cyc();
    bus.rv_gnt = 1'b0;
    settle();
    check("lk1.wait_req", 32'(bus.rv_req), 32'd0);
    check("lk1.wait_trvk", 32'(trvk_en), 32'd0);
    bus.rv_rvalid = 1'b1;
    bus.rv_rdata = 32'h0000_0002;
    cyc();
    bus.rv_rvalid = 1'b0;
    trvk("lk1", 1'b1, 5'd4, 1'b1);
    cyc();
    check("lk1.busy", 32'(busy), 32'd0);

    // base 0x8000_0108 -> granule 33: word 0x8F00_0004, bit 1 clear; gnt+rvalid together
    resp(1'b1, 5'd6, 1'b1, 32'h8000_0108);
    cyc();
    resp(1'b0, 5'd0, 1'b0, 32'h0);
    cyc();
    check("lk2.addr", bus.rv_addr, 32'h8F00_0004);
    bus.rv_gnt = 1'b1;
    bus.rv_rvalid = 1'b1;
    bus.rv_rdata = 32'hFFFF_FFFD;
    cyc();
    bus.rv_gnt = 1'b0;
    bus.rv_rvalid = 1'b0;
    trvk("lk2", 1'b1, 5'd6, 1'b0);
    cyc();

    // last granule of the heap: word 0x8F00_0FFC, bit 31
    resp(1'b1, 5'd11, 1'b1, 32'h8003_FFF8);
    cyc();
    resp(1'b0, 5'd0, 1'b0, 32'h0);
    cyc();
    check("lk3.addr", bus.rv_addr, 32'h8F00_0FFC);
    bus.rv_gnt = 1'b1;
    bus.rv_rvalid = 1'b1;
    bus.rv_rdata = 32'h8000_0000;
    cyc();
    bus.rv_gnt = 1'b0;
    bus.rv_rvalid = 1'b0;
    trvk("lk3", 1'b1, 5'd11, 1'b1);
    cyc();

    // tagged outside heap: no lookup
    resp(1'b1, 5'd8, 1'b1, 32'h9000_0000);
    cyc();
    resp(1'b0, 5'd0, 1'b0, 32'h0);
    settle();
    check("oob.req", 32'(bus.rv_req), 32'd0);
    cyc();
    trvk("oob", 1'b1, 5'd8, 1'b0);
    check("oob.req2", 32'(bus.rv_req), 32'd0);
    cyc();

    // two tagged back to back fill the FIFO; third waits while gnt is low
    resp(1'b1, 5'd3, 1'b1, 32'h8000_0000);
    cyc();
    resp(1'b1, 5'd7, 1'b1, 32'h8000_0040);
    settle();
    check("full.ready1", 32'(bus.cap_resp_ready), 32'd1);
    cyc();
    resp(1'b1, 5'd10, 1'b0, 32'h0000_1000);
    settle();
    check("full.ready0", 32'(bus.cap_resp_ready), 32'd0);
    check("full.req", 32'(bus.rv_req), 32'd1);
    check("full.addr", bus.rv_addr, 32'h8F00_0000);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("full.hold_ready", 32'(bus.cap_resp_ready), 32'd0);
      check("full.hold_trvk", 32'(trvk_en), 32'd0);
    end
    bus.rv_gnt = 1'b1;
    bus.rv_rvalid = 1'b1;
    bus.rv_rdata = 32'h0000_0001;
    cyc();
    bus.rv_gnt = 1'b0;
    bus.rv_rvalid = 1'b0;
    trvk("ord.rd3", 1'b1, 5'd3, 1'b1);
    check("ord.ready_freed", 32'(bus.cap_resp_ready), 32'd1);
    cyc();
    resp(1'b0, 5'd0, 1'b0, 32'h0);
    settle();
    check("ord.gap", 32'(trvk_en), 32'd0);
    check("ord.req7", 32'(bus.rv_req), 32'd1);
    check("ord.full_again", 32'(bus.cap_resp_ready), 32'd0);
    bus.rv_gnt = 1'b1;
    bus.rv_rvalid = 1'b1;
    bus.rv_rdata = 32'hFFFF_FEFF;
    cyc();
    bus.rv_gnt = 1'b0;
    bus.rv_rvalid = 1'b0;
    trvk("ord.rd7", 1'b1, 5'd7, 1'b0);
    cyc();
    trvk("ord.rd10", 1'b1, 5'd10, 1'b0);
    cyc();
    check("ord.busy", 32'(busy), 32'd0);
    check("ord.trvk_end", 32'(trvk_en), 32'd0);

    // trsv and trvk to the same register in one cycle
    resp(1'b1, 5'd9, 1'b0, 32'h0);
    cyc();
    resp(1'b0, 5'd0, 1'b0, 32'h0);
    cyc();
    ld_issue = 1'b1;
    ld_rd = 5'd9;
    settle();
    check("same.trsv_en", 32'(trsv_en), 32'd1);
    check("same.trsv_addr", 32'(trsv_addr), 32'd9);
    trvk("same", 1'b1, 5'd9, 1'b0);
    ld_rd = 5'd0;
    settle();
    check("same.trsv_rd0", 32'(trsv_en), 32'd0);
    ld_issue = 1'b0;
    cyc();

    // response to x0 is dropped
    resp(1'b1, 5'd0, 1'b1, 32'h8000_0000);
    cyc();
    resp(1'b0, 5'd0, 1'b0, 32'h0);
    settle();
    check("x0.busy", 32'(busy), 32'd0);
    cyc();
    check("x0.trvk", 32'(trvk_en), 32'd0);

    // reset while waiting for bitmap data; late rvalid ignored
    resp(1'b1, 5'd12, 1'b1, 32'h8000_0000);
    cyc();
    resp(1'b0, 5'd0, 1'b0, 32'h0);
    cyc();
    bus.rv_gnt = 1'b1;
    cyc();
    bus.rv_gnt = 1'b0;
    settle();
    check("rstw.busy_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.rv_rvalid = 1'b1;
    bus.rv_rdata = 32'hFFFF_FFFF;
    settle();
    check("rstw.busy", 32'(busy), 32'd0);
    check("rstw.ready", 32'(bus.cap_resp_ready), 32'd1);
    check("rstw.trvk0", 32'(trvk_en), 32'd0);
    cyc();
    bus.rv_rvalid = 1'b0;
    check("rstw.trvk1", 32'(trvk_en), 32'd0);
    check("rstw.busy1", 32'(busy), 32'd0);
    cyc();
    check("rstw.trvk2", 32'(trvk_en), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
